// File: rtl/secure_cmd_issuer.sv
// Command issuer for a secure processor: queues requests in a FIFO, issues them one at a
// time as a single-cycle command pulse, and returns read results or illegal-command errors.
module secure_cmd_issuer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_cmd,
    input  logic [31:0] req_data,
    output logic [3:0]  proc_cmd,
    output logic [31:0] proc_data,
    input  logic [31:0] proc_data_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [3:0] CMD_NOP = 4'b0000;
    localparam logic [3:0] CMD_WR0 = 4'b0001;
    localparam logic [3:0] CMD_RD0 = 4'b0010;
    localparam logic [3:0] CMD_WR1 = 4'b0011;
    localparam logic [3:0] CMD_RD1 = 4'b0100;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] data;
    } req_t;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    function automatic logic is_read(input logic [3:0] c);
        return (c == CMD_RD0) || (c == CMD_RD1);
    endfunction

    function automatic logic is_legal(input logic [3:0] c);
        return (c == CMD_WR0) || (c == CMD_RD0) || (c == CMD_WR1) || (c == CMD_RD1);
    endfunction

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, empty;

    state_t        state, state_nxt;
    logic [3:0]    proc_cmd_nxt;
    logic [31:0]   proc_data_nxt, rsp_data_nxt;
    logic          rsp_valid_nxt, rsp_err_nxt;

    // req_ready is forced low during reset so nothing is accepted into a FIFO being cleared.
    assign empty     = (count == '0);
    assign req_ready = rst_n && (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign head      = mem[rd_ptr];

    always_comb begin
        state_nxt     = state;
        proc_cmd_nxt  = proc_cmd;
        proc_data_nxt = proc_data;
        rsp_valid_nxt = rsp_valid;
        rsp_data_nxt  = rsp_data;
        rsp_err_nxt   = rsp_err;
        pop           = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (is_legal(head.cmd)) begin
                        proc_cmd_nxt  = head.cmd;
                        proc_data_nxt = head.data;
                        state_nxt     = ISSUE;
                    end else begin
                        rsp_valid_nxt = 1'b1;
                        rsp_err_nxt   = 1'b1;
                        rsp_data_nxt  = '0;
                        state_nxt     = RESP;
                    end
                end
            end
            ISSUE: begin
                // Command is a one-cycle pulse; proc_data keeps the operand.
                proc_cmd_nxt = CMD_NOP;
                state_nxt    = is_read(proc_cmd) ? CAPTURE : IDLE;
            end
            CAPTURE: begin
                rsp_valid_nxt = 1'b1;
                rsp_err_nxt   = 1'b0;
                rsp_data_nxt  = proc_data_out;
                state_nxt     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            proc_cmd  <= CMD_NOP;
            proc_data <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            proc_cmd  <= proc_cmd_nxt;
            proc_data <= proc_data_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_err   <= rsp_err_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{cmd: req_cmd, data: req_data};
    end

endmodule

// File: tb/tb_secure_cmd_issuer.sv
// Bench for secure_cmd_issuer: a small two-register processor model, an in-order response
// scoreboard filled at request acceptance, and per-scenario timing and handshake checks.
module tb_secure_cmd_issuer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [31:0] req_data;
    logic [3:0]  proc_cmd;
    logic [31:0] proc_data;
    logic [31:0] proc_data_out = '0;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] mra = '0, mrb = '0;
    logic [31:0] pa = '0, pb = '0;

    secure_cmd_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_data(req_data),
        .proc_cmd(proc_cmd), .proc_data(proc_data), .proc_data_out(proc_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Processor: 1/3 write register A/B, 2/4 read it back into a registered result.
    always @(posedge clk) begin
        case (proc_cmd)
            4'h1: pa <= proc_data;
            4'h3: pb <= proc_data;
            4'h2: proc_data_out <= pa;
            4'h4: proc_data_out <= pb;
            default: ;
        endcase
    end

    // Response monitor: stability while stalled, in-order scoreboard compare on handshake.
    logic        held = 1'b0;
    logic [31:0] h_data;
    logic        h_err;
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            held = 1'b0;
        end else if (rsp_valid) begin
            if (held) begin
                checks++;
                if (rsp_data !== h_data || rsp_err !== h_err) begin
                    errors++;
                    $display("FAIL rsp_stable got %h/%b exp %h/%b", rsp_data, rsp_err, h_data, h_err);
                end
            end
            if (rsp_ready) begin
                held = 1'b0;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_unexpected got %h/%b exp none", rsp_data, rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_data !== e.data || rsp_err !== e.err) begin
                        errors++;
                        $display("FAIL rsp_order got %h/%b exp %h/%b", rsp_data, rsp_err, e.data, e.err);
                    end
                end
            end else begin
                held   = 1'b1;
                h_data = rsp_data;
                h_err  = rsp_err;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request from the post-edge phase; returns just after the accepting edge.
    task automatic push_req(input logic [3:0] cmd, input logic [31:0] data);
        rsp_t e;
        bit   done = 0;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_data  = data;
        for (int i = 0; i < 100 && !done; i++) begin
            if (req_ready) done = 1;
            tick();
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout got not_accepted exp accepted cmd %h", cmd);
        end else begin
            case (cmd)
                4'h1: mra = data;
                4'h3: mrb = data;
                4'h2: begin e.err = 1'b0; e.data = mra; exp_q.push_back(e); end
                4'h4: begin e.err = 1'b0; e.data = mrb; exp_q.push_back(e); end
                default: begin e.err = 1'b1; e.data = '0; exp_q.push_back(e); end
            endcase
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (exp_q.size() != 0 || rsp_valid); i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_data = '0; rsp_ready = 1'b0;
        tick(); tick();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
        checks++;
        if (proc_cmd !== 4'h0 || proc_data !== 32'h0) begin
            errors++; $display("FAIL reset_proc got %h/%h exp 0/0", proc_cmd, proc_data);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got %b/%h/%b exp 0/0/0", rsp_valid, rsp_data, rsp_err);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [3:0] exp_w [3] = '{4'h0, 4'h1, 4'h0};
        rsp_ready = 1'b1;
        push_req(4'h1, 32'h12345678);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (proc_cmd !== exp_w[k]) begin
                errors++; $display("FAIL wr_seq[%0d] got %h exp %h", k, proc_cmd, exp_w[k]);
            end
            if (k < 2) tick();
        end
        checks++;
        if (proc_data !== 32'h12345678) begin
            errors++; $display("FAIL proc_data_hold got %h exp 12345678", proc_data);
        end
        tick(); tick();
        push_req(4'h2, 32'hDEAD0000);
        checks++;
        if (proc_cmd !== 4'h0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_e0 got %h/%b exp 0/0", proc_cmd, rsp_valid);
        end
        tick();
        checks++;
        if (proc_cmd !== 4'h2) begin errors++; $display("FAIL rd_e1 got %h exp 2", proc_cmd); end
        tick();
        checks++;
        if (proc_cmd !== 4'h0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rd_e2 got %h/%b exp 0/0", proc_cmd, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL rd_e3 got %b/%h/%b exp 1/12345678/0", rsp_valid, rsp_data, rsp_err);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_e4 got %b exp 0", rsp_valid); end
    endtask

    task automatic test_illegal();
        bit saw7 = 0, saw_err = 0;
        rsp_ready = 1'b1;
        push_req(4'h3, 32'hA5A55A5A);
        push_req(4'h7, 32'h11111111);
        push_req(4'h4, 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (proc_cmd == 4'h7) saw7 = 1;
            if (rsp_valid && rsp_err) saw_err = 1;
            tick();
        end
        checks++;
        if (saw7 != 0) begin errors++; $display("FAIL illegal_issued got 1 exp 0"); end
        checks++;
        if (saw_err != 1) begin errors++; $display("FAIL illegal_err got 0 exp 1"); end
        drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL illegal_drain got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        push_req(4'h2, 32'h0);
        push_req(4'h1, 32'hCAFE0001);
        push_req(4'h2, 32'h0);
        push_req(4'h3, 32'hBEEF0003);
        push_req(4'h4, 32'h0);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", req_ready); end
        req_valid = 1'b1; req_cmd = 4'h1; req_data = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (req_ready !== 1'b0) begin errors++; $display("FAIL full_hold[%0d] got %b exp 0", i, req_ready); end
            tick();
        end
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_rsp_valid got %b exp 1", rsp_valid); end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b exp 0", req_ready); end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready got %b exp 1", req_ready); end
        drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_push_pop_wrap();
        rsp_ready = 1'b0;
        push_req(4'h4, 32'h0);
        push_req(4'h1, 32'h0A0A0001);
        push_req(4'h2, 32'h0);
        push_req(4'h3, 32'h0B0B0003);
        for (int i = 0; i < 10 && !rsp_valid; i++) tick();
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL pp_rsp_wait got %b exp 1", rsp_valid); end
        rsp_ready = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL pp_pre_ready got %b exp 1", req_ready); end
        push_req(4'h4, 32'h0);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL pp_same_edge got %b exp 1", req_ready); end
        push_req(4'h2, 32'h0);
        checks++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL pp_now_full got %b exp 0", req_ready); end
        drain();
        for (int i = 0; i < 3 * DEPTH; i++) push_req(4'($urandom_range(0, 5)), $urandom);
        drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d exp 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit activity = 0;
        rsp_ready = 1'b1;
        push_req(4'h4, 32'h0);
        push_req(4'h2, 32'h0);
        push_req(4'h4, 32'h0);
        rst_n = 1'b0;
        tick();
        checks++;
        if (rsp_valid !== 1'b0 || proc_cmd !== 4'h0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL mid_reset got %b/%h/%b exp 0/0/0", rsp_valid, proc_cmd, req_ready);
        end
        exp_q.delete();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (proc_cmd != 4'h0 || rsp_valid) activity = 1;
            tick();
        end
        checks++;
        if (activity != 0) begin errors++; $display("FAIL mid_reset_stale got 1 exp 0"); end
        push_req(4'h4, 32'h0);
        drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset_drain got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_backpressure();
        test_push_pop_wrap();
        test_reset_mid();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/secure_cmd_issuer.md
SECURE_CMD_ISSUER -- requirements
Module: secure_cmd_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  upstream request valid.
REQ-005 SHALL have port req_ready  output  1  FIFO can accept a request.
REQ-006 SHALL have port req_cmd  input  4  requested processor command.
REQ-007 SHALL have port req_data  input  32  requested operand.
REQ-008 SHALL have port proc_cmd  output  4  command to the secure processor, registered.
REQ-009 SHALL have port proc_data  output  32  operand to the secure processor, registered.
REQ-010 SHALL have port proc_data_out  input  32  processor registered result.
REQ-011 SHALL have port rsp_valid  output  1  response valid.
REQ-012 SHALL have port rsp_ready  input  1  downstream accepts response.
REQ-013 SHALL have port rsp_data  output  32  read result.
REQ-014 SHALL have port rsp_err  output  1  request rejected as illegal.

Function
REQ-015 SHALL accept a request on any rising edge with req_valid=1 and req_ready=1, pushing {req_cmd, req_data} into a DEPTH-entry FIFO.
REQ-016 SHALL drive req_ready = FIFO not full and rst_n=1; no push when full, with no FIFO entry overwritten.
REQ-017 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-018 IDLE: proc_cmd=4'b0000; if FIFO non-empty, pop the head on the edge; legal cmd (0001, 0010, 0011, 0100) -> load proc_cmd/proc_data, go ISSUE; any other cmd -> no issue, rsp_err=1, rsp_data=0, rsp_valid=1, go RESP.
REQ-019 ISSUE: proc_cmd held for exactly one cycle; next edge sets proc_cmd=4'b0000; read cmd (0010, 0100) -> CAPTURE; write cmd (0001, 0011) -> IDLE, no response.
REQ-020 CAPTURE: one cycle; at its closing edge rsp_data <= proc_data_out, rsp_err <= 0, rsp_valid <= 1, go RESP.
REQ-021 RESP: hold rsp_valid, rsp_data, rsp_err stable until an edge with rsp_ready=1; on that edge clear rsp_valid and go IDLE.
REQ-022 Read latency: a read accepted at edge E0 into an empty FIFO in IDLE SHALL have proc_cmd valid after E1 and rsp_valid=1 after E3.
REQ-023 Write throughput: back-to-back writes SHALL be issued one per 2 cycles; proc_cmd returns to 4'b0000 between issues.
REQ-024 Requests SHALL be issued and responded to in strict acceptance order, with at most one command outstanding.
REQ-025 Simultaneous push and pop on one edge SHALL both take effect, with occupancy unchanged; with the FIFO full, pop frees a slot visible as req_ready=1 the following cycle.
REQ-026 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter range 0..DEPTH.
REQ-027 proc_data SHALL retain its last issued value when proc_cmd=4'b0000.
REQ-028 Upstream acceptance SHALL continue while in RESP under backpressure, until full.

Reset
REQ-029 When rst_n=0 at a rising edge: FIFO empty, pointers/count 0, state IDLE, proc_cmd=0, proc_data=0, rsp_valid=0, rsp_data=0, rsp_err=0.
REQ-030 req_ready SHALL be 0 while rst_n=0.
REQ-031 Reset mid-operation (any state) SHALL discard queued and in-flight requests, with no response emitted for them.

Verification
REQ-032 Write 0001/0x12345678 then read 0010 with rsp_ready=1 -> proc_cmd sequence 1,0,2,0; rsp_data=0x12345678, rsp_err=0, rsp_valid rising 3 cycles after read acceptance.
REQ-033 Illegal cmd 4'b0111 -> proc_cmd stays 0; response rsp_err=1, rsp_data=0; next queued request then processed normally.
REQ-034 rsp_ready=0, push 0010 plus 4 more requests -> req_ready=0 after FIFO full; response held stable; releasing rsp_ready drains all in order.
REQ-035 Push and pop on the same edge at occupancy DEPTH-1 -> occupancy unchanged, no loss; pointer wrap exercised over 3*DEPTH requests with data intact.
REQ-036 Assert rst_n=0 during CAPTURE -> next cycle rsp_valid=0, proc_cmd=0, FIFO empty, no stale response after release.
